// File: rtl/qs_enq.sv
// qs_enq: enqueue stage of the sorter. Streams packets into the current memory bank and
// publishes each finished bank to the scoreboard. Optional stats counters: QS_ENQ_STATS_EN.

package qs_enq_pkg;
    localparam int QS_W       = 32;
    localparam int QS_N       = 16;
    localparam int QS_BANKS_N = 2;

    typedef logic [$clog2(QS_N)-1:0]       addr_t;
    typedef logic [$clog2(QS_BANKS_N)-1:0] bank_id_t;

    typedef enum logic [1:0] {
        BANK_IDLE    = 2'd0,
        BANK_LOADING = 2'd1,
        BANK_LOADED  = 2'd2,
        BANK_SORTED  = 2'd3
    } bank_status_t;

    typedef struct packed {
        bank_status_t status;
        addr_t        n;
        logic         err;
    } bank_state_t;
endpackage

// state | meaning
// IDLE  | waiting for SOP; needs the current bank to read BANK_IDLE
// LOAD  | writing packet words at cnt
// DRAIN | bank full; discard words until EOP
module qs_enq
    import qs_enq_pkg::*;
#(
    parameter int W       = QS_W,
    parameter int N       = QS_N,
    parameter int BANKS_N = QS_BANKS_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic         in_sop,
    input  logic         in_eop,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output bank_id_t     bank_idx_r,
    input  bank_state_t  bank_in,
    output logic         bank_out_vld,
    output bank_state_t  bank_out,
    output logic         wr_en_r,
    output addr_t        wr_addr_r,
    output logic [W-1:0] wr_data_r
`ifdef QS_ENQ_STATS_EN
    ,
    output logic [15:0]  pkt_cnt_r,
    output logic [15:0]  drop_cnt_r
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t   state_r, state_nxt;
    addr_t    cnt_r, cnt_nxt;
    logic     err_r, err_nxt;
    bank_id_t bank_idx_nxt;
    logic     accept;
    logic     commit;
    logic     drop;
    logic     wr_en_nxt;
    addr_t    wr_addr_nxt;

    always_comb begin
        in_rdy       = rst & ((state_r != S_IDLE) | (bank_in.status == BANK_IDLE));
        accept       = in_vld & in_rdy;
        state_nxt    = state_r;
        cnt_nxt      = cnt_r;
        err_nxt      = err_r;
        bank_idx_nxt = bank_idx_r;
        bank_out_vld = 1'b0;
        bank_out     = bank_in;
        wr_en_nxt    = 1'b0;
        wr_addr_nxt  = cnt_r;
        commit       = 1'b0;
        drop         = 1'b0;

        if (accept) begin
            case (state_r)
                S_IDLE: begin
                    if (in_sop) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = '0;
                        cnt_nxt     = addr_t'(1);
                        if (in_eop) begin
                            commit     = 1'b1;
                            bank_out.n = '0;
                        end else begin
                            bank_out_vld    = 1'b1;
                            bank_out.status = BANK_LOADING;
                            bank_out.err    = 1'b0;
                            state_nxt       = S_LOAD;
                        end
                    end else begin
                        drop = 1'b1;
                    end
                end
                S_LOAD: begin
                    // A SOP here means the previous EOP was lost: restart the bank, flag it.
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = in_sop ? addr_t'(0) : cnt_r;
                    err_nxt     = err_r | in_sop;
                    if (in_eop) begin
                        commit     = 1'b1;
                        bank_out.n = wr_addr_nxt;
                    end else if (in_sop) begin
                        cnt_nxt = addr_t'(1);
                    end else if (cnt_r == addr_t'(N-1)) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_DRAIN;
                    end else begin
                        cnt_nxt = addr_t'(cnt_r + 1'b1);
                    end
                end
                S_DRAIN: begin
                    drop = 1'b1;
                    if (in_eop) begin
                        commit     = 1'b1;
                        bank_out.n = addr_t'(N-1);
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        if (commit) begin
            bank_out_vld    = 1'b1;
            bank_out.status = BANK_LOADED;
            bank_out.err    = err_nxt;
            cnt_nxt         = '0;
            err_nxt         = 1'b0;
            state_nxt       = S_IDLE;
            bank_idx_nxt    = (bank_idx_r == bank_id_t'(BANKS_N-1)) ? '0
                                                                  : bank_id_t'(bank_idx_r + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= '0;
            err_r      <= 1'b0;
            bank_idx_r <= '0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= '0;
            wr_data_r  <= '0;
        end else begin
            state_r    <= state_nxt;
            cnt_r      <= cnt_nxt;
            err_r      <= err_nxt;
            bank_idx_r <= bank_idx_nxt;
            wr_en_r    <= wr_en_nxt;
            if (wr_en_nxt) begin
                wr_addr_r <= wr_addr_nxt;
                wr_data_r <= in_dat;
            end
        end
    end

`ifdef QS_ENQ_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt_r  <= '0;
            drop_cnt_r <= '0;
        end else begin
            if (commit && pkt_cnt_r != 16'hFFFF)
                pkt_cnt_r <= pkt_cnt_r + 16'd1;
            if (drop && drop_cnt_r != 16'hFFFF)
                drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qs_enq.sv
// Bench for qs_enq: directed and random packets checked against a packet-level model
// (segment arithmetic) with the bench acting as the bank scoreboard.
module tb_qs_enq;
    import qs_enq_pkg::*;

    localparam int N  = QS_N;
    localparam int BN = QS_BANKS_N;
    localparam int W  = QS_W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic [W-1:0] in_dat = '0;
    logic         in_rdy;
    bank_id_t     bank_idx_r;
    bank_state_t  bank_in;
    logic         bank_out_vld;
    bank_state_t  bank_out;
    logic         wr_en_r;
    addr_t        wr_addr_r;
    logic [W-1:0] wr_data_r;
`ifdef QS_ENQ_STATS_EN
    logic [15:0]  pkt_cnt_r, drop_cnt_r;
`endif

    bank_state_t  sb [BN];
    assign bank_in = sb[bank_idx_r];

    qs_enq dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_dat(in_dat),
        .in_rdy(in_rdy), .bank_idx_r(bank_idx_r), .bank_in(bank_in),
        .bank_out_vld(bank_out_vld), .bank_out(bank_out),
        .wr_en_r(wr_en_r), .wr_addr_r(wr_addr_r), .wr_data_r(wr_data_r)
`ifdef QS_ENQ_STATS_EN
        , .pkt_cnt_r(pkt_cnt_r), .drop_cnt_r(drop_cnt_r)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_bank = 0;
    int exp_drops = 0;
    int exp_pkts = 0;
    logic [W-1:0] pkt_dat[$];

    logic         s_rdy, s_bvld, s_wen;
    bank_state_t  s_bout;
    addr_t        s_waddr;
    logic [W-1:0] s_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, sample combinational outputs, clock, then apply scoreboard write.
    task automatic cycle(input logic v, input logic s, input logic e, input logic [W-1:0] d);
        bank_id_t idx;
        in_vld = v; in_sop = s; in_eop = e; in_dat = d;
        #1;
        s_rdy  = in_rdy;
        s_bvld = bank_out_vld;
        s_bout = bank_out;
        idx    = bank_idx_r;
        @(posedge clk);
        #1;
        if (s_bvld) sb[idx] = s_bout;
        s_wen   = wr_en_r;
        s_waddr = wr_addr_r;
        s_wdata = wr_data_r;
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic free_bank();
        sb[exp_bank].status = BANK_IDLE;
    endtask

    // rs>0 places a second SOP at word rs (must be below N so it lands before overflow).
    task automatic send_pkt(input int len, input int rs);
        for (int i = 0; i < len; i++) begin
            logic sop, eop, exp_wr, exp_bvld;
            logic [W-1:0] d;
            int seg, idx, seglen, exp_n;
            sop = (i == 0) || (rs > 0 && i == rs);
            eop = (i == len-1);
            d   = (i < pkt_dat.size()) ? pkt_dat[i] : W'($urandom);
            seg = (rs > 0 && i >= rs) ? rs : 0;
            idx = i - seg;
            exp_wr   = (idx < N);
            exp_bvld = eop || (i == 0);
            cycle(1'b1, sop, eop, d);
            chk("in_rdy", 64'(s_rdy), 64'(1));
            chk("bank_out_vld", 64'(s_bvld), 64'(exp_bvld));
            if (eop) begin
                seglen = len - seg;
                exp_n  = ((seglen > N) ? N : seglen) - 1;
                chk("commit_status", 64'(s_bout.status), 64'(BANK_LOADED));
                chk("commit_n", 64'(s_bout.n), 64'(exp_n));
                chk("commit_err", 64'(s_bout.err), 64'((rs > 0) || (seglen > N)));
                exp_bank = (exp_bank + 1) % BN;
                exp_pkts++;
            end else if (i == 0) begin
                chk("open_status", 64'(s_bout.status), 64'(BANK_LOADING));
                chk("open_err", 64'(s_bout.err), 64'(0));
            end
            chk("wr_en", 64'(s_wen), 64'(exp_wr));
            if (exp_wr) begin
                chk("wr_addr", 64'(s_waddr), 64'(idx));
                chk("wr_data", 64'(s_wdata), 64'(d));
            end else begin
                exp_drops++;
            end
        end
        chk("bank_idx", 64'(bank_idx_r), 64'(exp_bank));
        pkt_dat.delete();
    endtask

    initial begin
        for (int b = 0; b < BN; b++) sb[b] = '{status: BANK_IDLE, n: '0, err: 1'b0};

        // Reset state, with a SOP being offered
        in_vld = 1'b1; in_sop = 1'b1; in_dat = 32'h55;
        #2;
        chk("rst_in_rdy", 64'(in_rdy), 64'(0));
        chk("rst_bank_out_vld", 64'(bank_out_vld), 64'(0));
        chk("rst_wr_en", 64'(wr_en_r), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr_r), 64'(0));
        chk("rst_wr_data", 64'(wr_data_r), 64'(0));
        chk("rst_bank_idx", 64'(bank_idx_r), 64'(0));
        in_vld = 1'b0; in_sop = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // T1: four-word packet
        pkt_dat = '{32'h3, 32'h1, 32'h4, 32'h1};
        send_pkt(4, 0);

        // T2: single-word packet
        free_bank();
        pkt_dat = '{32'hA};
        send_pkt(1, 0);

        // T4 (also proves T2 left the FSM idle): bank not free blocks the SOP
        sb[exp_bank].status = BANK_SORTED;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, 1'b0, W'($urandom));
            chk("blocked_rdy", 64'(s_rdy), 64'(0));
            chk("blocked_bvld", 64'(s_bvld), 64'(0));
            chk("blocked_wr_en", 64'(s_wen), 64'(0));
        end
        free_bank();
        send_pkt(3, 0);

        // T3: overflow, 20 words into a 16-word bank
        free_bank();
        send_pkt(20, 0);
`ifdef QS_ENQ_STATS_EN
        chk("drop_cnt_t3", 64'(drop_cnt_r), 64'(exp_drops));
`endif

        // T5: lost EOP, SOP,w,w,SOP,w,EOP
        free_bank();
        send_pkt(6, 3);

        // Stray non-SOP words in IDLE are dropped
        free_bank();
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b0, $urandom_range(0, 1) == 1, W'($urandom));
            chk("stray_rdy", 64'(s_rdy), 64'(1));
            chk("stray_bvld", 64'(s_bvld), 64'(0));
            chk("stray_wr_en", 64'(s_wen), 64'(0));
            exp_drops++;
        end

        // T6 and random packets: bank rotation, lengths around the overflow boundary
        for (int p = 0; p < 30; p++) begin
            int len, rs, gap, hi;
            len = $urandom_range(1, N + 6);
            hi  = (len - 1 < N - 1) ? len - 1 : N - 1;
            rs  = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, hi) : 0;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cycle(1'b0, 1'b0, 1'b0, W'($urandom));
                chk("gap_wr_en", 64'(s_wen), 64'(0));
            end
            free_bank();
            send_pkt(len, rs);
        end

`ifdef QS_ENQ_STATS_EN
        chk("pkt_cnt", 64'(pkt_cnt_r), 64'(exp_pkts));
        chk("drop_cnt", 64'(drop_cnt_r), 64'(exp_drops));
`endif

        // Reset mid-packet with a non-zero bank index
        if (exp_bank == 0) begin
            free_bank();
            send_pkt(2, 0);
        end
        free_bank();
        cycle(1'b1, 1'b1, 1'b0, W'($urandom));
        cycle(1'b1, 1'b0, 1'b0, W'($urandom));
        chk("pre_rst_wr_en", 64'(s_wen), 64'(1));
        in_vld = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_wr_en", 64'(wr_en_r), 64'(0));
        chk("mid_rst_in_rdy", 64'(in_rdy), 64'(0));
        chk("mid_rst_bank_idx", 64'(bank_idx_r), 64'(0));
        chk("mid_rst_bvld", 64'(bank_out_vld), 64'(0));
        in_vld = 1'b0;
        for (int b = 0; b < BN; b++) sb[b] = '{status: BANK_IDLE, n: '0, err: 1'b0};
        exp_bank = 0; exp_pkts = 0; exp_drops = 0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        send_pkt(5, 0);
`ifdef QS_ENQ_STATS_EN
        chk("post_rst_pkt_cnt", 64'(pkt_cnt_r), 64'(exp_pkts));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
